// File: rtl/decoder_pipe.sv
// decoder_pipe: registered RV32I instruction decode behind a valid/ready
// handshake, with optional 2-entry skid buffer, illegal-instruction
// detection, optional RV32M acceptance and a pipeline flush.
module decoder_pipe #(
  parameter bit ENABLE_MULDIV = 1'b0,
  parameter bit ENABLE_SKID   = 1'b1
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_flush,
  input  logic        I_valid,
  output logic        O_ready,
  input  logic [31:0] I_instr,
  output logic [4:0]  O_rs1,
  output logic [4:0]  O_rs2,
  output logic        O_valid,
  input  logic        I_ready,
  output logic [4:0]  O_opcode,
  output logic [4:0]  O_rd,
  output logic [2:0]  O_funct3,
  output logic [6:0]  O_funct7,
  output logic [31:0] O_imm,
  output logic [5:0]  O_branchmask,
  output logic        O_illegal
);

  localparam logic [4:0] OPC_LOAD    = 5'b00000;
  localparam logic [4:0] OPC_MISCMEM = 5'b00011;
  localparam logic [4:0] OPC_OPIMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC   = 5'b00101;
  localparam logic [4:0] OPC_STORE   = 5'b01000;
  localparam logic [4:0] OPC_OP      = 5'b01100;
  localparam logic [4:0] OPC_LUI     = 5'b01101;
  localparam logic [4:0] OPC_BRANCH  = 5'b11000;
  localparam logic [4:0] OPC_JALR    = 5'b11001;
  localparam logic [4:0] OPC_JAL     = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM  = 5'b11100;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [5:0]  branchmask;
    logic        illegal;
  } dec_t;

  dec_t dec_d;
  logic opBad;
  logic outValid;
  logic readyOut;
  dec_t outData;

  // Register-file read addresses come straight from the incoming word.
  assign O_rs1 = I_instr[19:15];
  assign O_rs2 = I_instr[24:20];

  // Decode the incoming word into the fields that get registered on accept.
  always_comb begin
    dec_d        = '0;
    opBad        = 1'b0;
    dec_d.opcode = I_instr[6:2];
    dec_d.rd     = I_instr[11:7];
    dec_d.funct3 = I_instr[14:12];
    dec_d.funct7 = I_instr[31:25];

    case (I_instr[6:2])
      OPC_STORE:           dec_d.imm = {{20{I_instr[31]}}, I_instr[31:25], I_instr[11:7]};
      OPC_BRANCH:          dec_d.imm = {{19{I_instr[31]}}, I_instr[31], I_instr[7],
                                        I_instr[30:25], I_instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:  dec_d.imm = {I_instr[31:12], 12'b0};
      OPC_JAL:             dec_d.imm = {{11{I_instr[31]}}, I_instr[31], I_instr[19:12],
                                        I_instr[20], I_instr[30:21], 1'b0};
      default:             dec_d.imm = {{20{I_instr[31]}}, I_instr[31:20]};
    endcase

    case (I_instr[14:12])
      3'b000:  dec_d.branchmask = 6'b000001;
      3'b001:  dec_d.branchmask = 6'b000010;
      3'b100:  dec_d.branchmask = 6'b000100;
      3'b101:  dec_d.branchmask = 6'b001000;
      3'b110:  dec_d.branchmask = 6'b010000;
      default: dec_d.branchmask = 6'b100000;
    endcase

    case (I_instr[6:2])
      OPC_LOAD:   opBad = (I_instr[14:12] == 3'b011) || (I_instr[14:12] == 3'b110) ||
                          (I_instr[14:12] == 3'b111);
      OPC_MISCMEM, OPC_AUIPC, OPC_LUI, OPC_JAL, OPC_SYSTEM:
                  opBad = 1'b0;
      OPC_OPIMM: begin
        if (I_instr[14:12] == 3'b001) begin
          opBad = (I_instr[31:25] != 7'b0000000);
        end else if (I_instr[14:12] == 3'b101) begin
          opBad = (I_instr[31:25] != 7'b0000000) && (I_instr[31:25] != 7'b0100000);
        end else begin
          opBad = 1'b0;
        end
      end
      OPC_STORE:  opBad = (I_instr[14:12] >= 3'b011);
      OPC_OP:     opBad = !((I_instr[31:25] == 7'b0000000) ||
                            ((I_instr[31:25] == 7'b0100000) &&
                             ((I_instr[14:12] == 3'b000) || (I_instr[14:12] == 3'b101))) ||
                            ((I_instr[31:25] == 7'b0000001) && ENABLE_MULDIV));
      OPC_BRANCH: opBad = (I_instr[14:12] == 3'b010) || (I_instr[14:12] == 3'b011);
      OPC_JALR:   opBad = (I_instr[14:12] != 3'b000);
      default:    opBad = 1'b1;
    endcase

    dec_d.illegal = opBad || (I_instr[1:0] != 2'b11);
  end

  generate
    if (ENABLE_SKID) begin : gSkid
      typedef enum logic [1:0] {EMPTY, FULL1, FULL2} state_t;
      state_t state_q;
      dec_t   out_q;
      dec_t   skid_q;
      logic   ready_q;

      // Skid FSM: output register plus one overflow slot, ready registered.
      always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
          state_q <= EMPTY;
          out_q   <= '0;
          skid_q  <= '0;
          ready_q <= 1'b1;
        end else if (I_flush) begin
          state_q <= EMPTY;
          ready_q <= 1'b1;
        end else begin
          case (state_q)
            EMPTY: begin
              if (I_valid && ready_q) begin
                out_q   <= dec_d;
                state_q <= FULL1;
              end
            end
            FULL1: begin
              if (I_valid && ready_q) begin
                if (I_ready) begin
                  out_q <= dec_d;
                end else begin
                  skid_q  <= dec_d;
                  state_q <= FULL2;
                  ready_q <= 1'b0;
                end
              end else if (I_ready) begin
                state_q <= EMPTY;
              end
            end
            FULL2: begin
              if (I_ready) begin
                out_q   <= skid_q;
                state_q <= FULL1;
                ready_q <= 1'b1;
              end
            end
            default: begin
              state_q <= EMPTY;
              ready_q <= 1'b1;
            end
          endcase
        end
      end

      assign outValid = (state_q != EMPTY);
      assign outData  = out_q;
      assign readyOut = ready_q;
    end else begin : gSingle
      logic valid_q;
      dec_t out_q;

      assign readyOut = !valid_q || I_ready;

      // Single output stage: load on accept, drop valid once consumed.
      always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
          valid_q <= 1'b0;
          out_q   <= '0;
        end else if (I_flush) begin
          valid_q <= 1'b0;
        end else if (I_valid && readyOut) begin
          out_q   <= dec_d;
          valid_q <= 1'b1;
        end else if (I_ready) begin
          valid_q <= 1'b0;
        end
      end

      assign outValid = valid_q;
      assign outData  = out_q;
    end
  endgenerate

  assign O_ready      = readyOut;
  assign O_valid      = outValid;
  assign O_opcode     = outData.opcode;
  assign O_rd         = outData.rd;
  assign O_funct3     = outData.funct3;
  assign O_funct7     = outData.funct7;
  assign O_imm        = outData.imm;
  assign O_branchmask = outData.branchmask;
  assign O_illegal    = outData.illegal;

endmodule

// File: tb/tb_decoder_pipe.sv
// tb_decoder_pipe: directed stimulus for decoder_pipe with a queue-based
// reference model; two instances differ only in RV32M acceptance.
module tb_decoder_pipe;

  localparam bit TB_SKID = 1'b1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        fetchValid = 1'b0;
  logic        downReady = 1'b0;
  logic [31:0] instr = '0;

  logic        dReady, dValid, dIllegal;
  logic [4:0]  dRs1, dRs2, dOpcode, dRd;
  logic [2:0]  dFunct3;
  logic [6:0]  dFunct7;
  logic [31:0] dImm;
  logic [5:0]  dBranchmask;

  logic        mReady, mValid, mIllegal;
  logic [4:0]  mRs1, mRs2, mOpcode, mRd;
  logic [2:0]  mFunct3;
  logic [6:0]  mFunct7;
  logic [31:0] mImm;
  logic [5:0]  mBranchmask;

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] modelQ[$];
  bit          zeroFlag = 1'b1;
  bit          mPush;
  bit          mPop;
  logic [4:0]  delivered[$];

  typedef struct packed {
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [5:0]  branchmask;
    logic        illegal;
  } exp_t;

  decoder_pipe #(.ENABLE_MULDIV(1'b0), .ENABLE_SKID(TB_SKID)) dut (
    .I_clk(clock), .I_reset(reset), .I_flush(flush), .I_valid(fetchValid),
    .O_ready(dReady), .I_instr(instr), .O_rs1(dRs1), .O_rs2(dRs2),
    .O_valid(dValid), .I_ready(downReady), .O_opcode(dOpcode), .O_rd(dRd),
    .O_funct3(dFunct3), .O_funct7(dFunct7), .O_imm(dImm),
    .O_branchmask(dBranchmask), .O_illegal(dIllegal)
  );

  decoder_pipe #(.ENABLE_MULDIV(1'b1), .ENABLE_SKID(TB_SKID)) dutM (
    .I_clk(clock), .I_reset(reset), .I_flush(flush), .I_valid(fetchValid),
    .O_ready(mReady), .I_instr(instr), .O_rs1(mRs1), .O_rs2(mRs2),
    .O_valid(mValid), .I_ready(downReady), .O_opcode(mOpcode), .O_rd(mRd),
    .O_funct3(mFunct3), .O_funct7(mFunct7), .O_imm(mImm),
    .O_branchmask(mBranchmask), .O_illegal(mIllegal)
  );

  always #5 clock = ~clock;

  // Expected decode of one word, built from field arithmetic and the legality rules.
  function automatic exp_t modelDecode(input logic [31:0] w, input bit mulOk);
    exp_t        e;
    int unsigned u;
    int          sw;
    int          opc;
    int          f3;
    int          f7;
    int          immV;
    bit          bad;
    u   = w;
    sw  = $signed(w);
    opc = int'((u >> 2) % 32);
    f3  = int'((u >> 12) % 8);
    f7  = int'(u >> 25);
    e.opcode = 5'(opc);
    e.rd     = 5'((u >> 7) % 32);
    e.funct3 = 3'(f3);
    e.funct7 = 7'(f7);
    case (opc)
      8:       immV = (sw >>> 25) * 32 + int'((u >> 7) % 32);
      24:      immV = (sw >>> 31) * 4096 + int'(w[7]) * 2048 + int'((u >> 25) % 64) * 32 +
                      int'((u >> 8) % 16) * 2;
      13, 5:   immV = int'(u - (u % 4096));
      27:      immV = (sw >>> 31) * 1048576 + int'((u >> 12) % 256) * 4096 +
                      int'(w[20]) * 2048 + int'((u >> 21) % 1024) * 2;
      default: immV = sw >>> 20;
    endcase
    e.imm = 32'(immV);
    case (f3)
      0:       e.branchmask = 6'd1;
      1:       e.branchmask = 6'd2;
      4:       e.branchmask = 6'd4;
      5:       e.branchmask = 6'd8;
      6:       e.branchmask = 6'd16;
      default: e.branchmask = 6'd32;
    endcase
    bad = ((u % 4) != 3);
    if (!(opc inside {0, 3, 4, 5, 8, 12, 13, 24, 25, 27, 28})) bad = 1'b1;
    if (opc == 24 && f3 inside {2, 3}) bad = 1'b1;
    if (opc == 0 && f3 inside {3, 6, 7}) bad = 1'b1;
    if (opc == 8 && f3 >= 3) bad = 1'b1;
    if (opc == 25 && f3 != 0) bad = 1'b1;
    if (opc == 12 && !(f7 == 0 || (f7 == 32 && f3 inside {0, 5}) || (f7 == 1 && mulOk))) bad = 1'b1;
    if (opc == 4 && f3 == 1 && f7 != 0) bad = 1'b1;
    if (opc == 4 && f3 == 5 && !(f7 inside {0, 32})) bad = 1'b1;
    e.illegal = bad;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] w, input logic v, input logic r, input logic f);
    @(posedge clock);
    #1;
    instr      = w;
    fetchValid = v;
    downReady  = r;
    flush      = f;
  endtask

  task automatic compareDut(input string tag, input bit mulOk, input logic vld, input logic rdy,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] opc, input logic [4:0] rd,
                            input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] imm, input logic [5:0] bm, input logic ill);
    exp_t e;
    checkOutput({tag, ".valid"}, 32'(vld), 32'(modelQ.size() > 0));
    if (TB_SKID) checkOutput({tag, ".ready"}, 32'(rdy), 32'(modelQ.size() < 2));
    else         checkOutput({tag, ".ready"}, 32'(rdy), 32'(modelQ.size() == 0 || downReady));
    checkOutput({tag, ".rs1"}, 32'(rs1), (instr >> 15) % 32);
    checkOutput({tag, ".rs2"}, 32'(rs2), (instr >> 20) % 32);
    if (modelQ.size() > 0) begin
      e = modelDecode(modelQ[0], mulOk);
      checkOutput({tag, ".opcode"}, 32'(opc), 32'(e.opcode));
      checkOutput({tag, ".rd"}, 32'(rd), 32'(e.rd));
      checkOutput({tag, ".funct3"}, 32'(f3), 32'(e.funct3));
      checkOutput({tag, ".funct7"}, 32'(f7), 32'(e.funct7));
      checkOutput({tag, ".imm"}, imm, e.imm);
      checkOutput({tag, ".branchmask"}, 32'(bm), 32'(e.branchmask));
      checkOutput({tag, ".illegal"}, 32'(ill), 32'(e.illegal));
    end else if (zeroFlag) begin
      checkOutput({tag, ".imm_zero"}, imm, 32'd0);
      checkOutput({tag, ".fields_zero"}, {5'd0, opc, rd, f3, f7, bm, ill}, 32'd0);
    end
  endtask

  // Reference model: occupancy queue updated by the handshake rules.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      modelQ.delete();
      zeroFlag = 1'b1;
    end else if (flush) begin
      modelQ.delete();
    end else begin
      mPush = fetchValid && (TB_SKID ? (modelQ.size() < 2) : (modelQ.size() == 0 || downReady));
      mPop  = (modelQ.size() > 0) && downReady;
      if (mPop) void'(modelQ.pop_front());
      if (mPush) begin
        modelQ.push_back(instr);
        zeroFlag = 1'b0;
      end
    end
  end

  // Compare both instances against the model mid-cycle and log transfers.
  always @(negedge clock) begin
    compareDut("dut", 1'b0, dValid, dReady, dRs1, dRs2, dOpcode, dRd, dFunct3, dFunct7,
               dImm, dBranchmask, dIllegal);
    compareDut("dutM", 1'b1, mValid, mReady, mRs1, mRs2, mOpcode, mRd, mFunct3, mFunct7,
               mImm, mBranchmask, mIllegal);
    if (dValid && downReady && !flush && !reset) delivered.push_back(dRd);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] extra[10];
    extra = '{32'h40005093, 32'h00001067, 32'h40000033, 32'h40001033, 32'h00000091,
              32'h00000073, 32'h0000000F, 32'h00003003, 32'h12345097, 32'h0000A083};

    $display("[TB] start");
    #12;
    checkOutput("reset.valid", 32'(dValid), 32'd0);
    checkOutput("reset.ready", 32'(dReady), 32'd1);
    checkOutput("reset.imm", dImm, 32'd0);
    #1 reset = 1'b0;

    applyStimulus(32'h00500093, 1'b1, 1'b1, 1'b0);
    checkOutput("addi.rs1_comb", 32'(dRs1), 32'd0);
    checkOutput("addi.rs2_comb", 32'(dRs2), 32'd5);
    checkOutput("addi.not_yet_valid", 32'(dValid), 32'd0);
    applyStimulus(32'hFE000EE3, 1'b1, 1'b1, 1'b0);
    checkOutput("addi.valid", 32'(dValid), 32'd1);
    checkOutput("addi.opcode", 32'(dOpcode), 32'd4);
    checkOutput("addi.rd", 32'(dRd), 32'd1);
    checkOutput("addi.imm", dImm, 32'h00000005);
    checkOutput("addi.illegal", 32'(dIllegal), 32'd0);
    applyStimulus(32'h123452B7, 1'b1, 1'b1, 1'b0);
    checkOutput("beq.imm", dImm, 32'hFFFFFFFC);
    checkOutput("beq.branchmask", 32'(dBranchmask), 32'h01);
    checkOutput("beq.illegal", 32'(dIllegal), 32'd0);
    applyStimulus(32'h023100B3, 1'b1, 1'b1, 1'b0);
    checkOutput("lui.imm", dImm, 32'h12345000);
    checkOutput("lui.rd", 32'(dRd), 32'd5);
    applyStimulus(32'h00000000, 1'b1, 1'b1, 1'b0);
    checkOutput("mul.illegal_nomd", 32'(dIllegal), 32'd1);
    checkOutput("mul.illegal_md", 32'(mIllegal), 32'd0);
    checkOutput("mul.funct7_md", 32'(mFunct7), 32'h01);
    applyStimulus(32'hFE20AC23, 1'b1, 1'b1, 1'b0);
    checkOutput("zero.illegal", 32'(dIllegal), 32'd1);
    checkOutput("sw.rs1_comb", 32'(dRs1), 32'd1);
    applyStimulus(32'h008000EF, 1'b1, 1'b1, 1'b0);
    checkOutput("sw.imm", dImm, 32'hFFFFFFF8);
    checkOutput("sw.illegal", 32'(dIllegal), 32'd0);
    applyStimulus(32'h00003023, 1'b1, 1'b1, 1'b0);
    checkOutput("jal.imm", dImm, 32'h00000008);
    checkOutput("jal.rd", 32'(dRd), 32'd1);
    applyStimulus(32'h02001013, 1'b1, 1'b1, 1'b0);
    checkOutput("badstore.illegal", 32'(dIllegal), 32'd1);
    foreach (extra[i]) applyStimulus(extra[i], 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);

    delivered.delete();
    applyStimulus(32'h00100513, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h00200593, 1'b1, 1'b0, 1'b0);
    checkOutput("bp.ready_one", 32'(dReady), 32'd1);
    checkOutput("bp.rd_first", 32'(dRd), 32'd10);
    applyStimulus(32'h00300613, 1'b1, 1'b0, 1'b0);
    checkOutput("bp.ready_full", 32'(dReady), 32'd0);
    applyStimulus(32'h00300613, 1'b1, 1'b1, 1'b0);
    checkOutput("bp.stable_rd", 32'(dRd), 32'd10);
    checkOutput("bp.stable_imm", dImm, 32'd1);
    applyStimulus(32'h00300613, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h00400693, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp.delivered_count", 32'(delivered.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < delivered.size()) checkOutput($sformatf("bp.order%0d", i), 32'(delivered[i]), 32'(10 + i));
    end

    delivered.delete();
    applyStimulus(32'h01400A13, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h01500A93, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h01600B13, 1'b1, 1'b0, 1'b1);
    checkOutput("flush.pre_full", 32'(dReady), 32'd0);
    checkOutput("flush.pre_valid", 32'(dValid), 32'd1);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("flush.valid", 32'(dValid), 32'd0);
    checkOutput("flush.ready", 32'(dReady), 32'd1);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("flush.none_delivered", 32'(delivered.size()), 32'd0);

    applyStimulus(32'h00700193, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h00800213, 1'b1, 1'b1, 1'b0);
    checkOutput("rst.pre_imm", dImm, 32'd7);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst.async_valid", 32'(dValid), 32'd0);
    checkOutput("rst.async_imm", dImm, 32'd0);
    checkOutput("rst.async_ready", 32'(dReady), 32'd1);
    #3 reset = 1'b0;
    applyStimulus(32'h00800213, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h00500093, 1'b1, 1'b1, 1'b0);
    checkOutput("rst.resume_rd", 32'(dRd), 32'd4);
    checkOutput("rst.resume_imm", dImm, 32'd8);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("rst.addi_rd", 32'(dRd), 32'd1);
    checkOutput("rst.addi_imm", dImm, 32'd5);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/decoder_pipe.md
Name: decoder_pipe

Overview:
- Parametrised successor of the RV32I decode stage: registered instruction decode behind a valid/ready handshake with a 2-entry skid buffer.
- Adds illegal-instruction detection, optional M-extension acceptance, and pipeline flush.
- Sits between fetch and the register-read/execute stage.
- rs1/rs2 are combinational from the input word so the register file can be read during decode.

Parameters:
- ENABLE_MULDIV, 0: 1 = funct7 0000001 under OP (01100) is legal (RV32M); 0 = it is flagged illegal.
- ENABLE_SKID, 1: 1 = 2-entry skid buffer with registered O_ready; 0 = single stage, O_ready = !O_valid | I_ready (combinational).

Ports:
- I_clk  in  1  clock
- I_reset  in  1  asynchronous active-high reset
- I_flush  in  1  discard all held and incoming instructions this cycle
- I_valid  in  1  I_instr valid from fetch
- O_ready  out  1  decoder can accept I_instr
- I_instr  in  32  instruction word
- O_rs1  out  5  I_instr[19:15], combinational
- O_rs2  out  5  I_instr[24:20], combinational
- O_valid  out  1  decoded fields valid to downstream
- I_ready  in  1  downstream accepts decoded fields
- O_opcode  out  5  instr[6:2]
- O_rd  out  5  instr[11:7]
- O_funct3  out  3  instr[14:12]
- O_funct7  out  7  instr[31:25]
- O_imm  out  32  sign-extended immediate
- O_branchmask  out  6  one-hot funct3 branch condition
- O_illegal  out  1  instruction illegal; fields still presented

Behaviour:
- Reset (async, I_reset=1): O_valid=0, skid valid=0, O_ready=1, all data outputs 0.
- Input handshake: accept when I_valid & O_ready. Output handshake: transfer when O_valid & I_ready.
- Latency: an accepted instruction appears on the outputs the next cycle. Throughput is 1/cycle while I_ready=1.
- Immediate, by opcode:
  - STORE 01000: S-type.
  - BRANCH 11000: B-type, bit0=0.
  - LUI 01101 / AUIPC 00101: {instr[31:12],12'b0}.
  - JAL 11011: J-type, bit0=0.
  - All others: I-type sign-extended instr[31:20].
- O_branchmask by funct3 (for every opcode):
  - 000 -> bit0, 001 -> bit1, 100 -> bit2, 101 -> bit3, 110 -> bit4.
  - All other values -> bit5.
  - Exactly one bit set whenever O_valid=1.
- O_illegal=1 if any of:
  - instr[1:0]!=11.
  - Opcode not in {LOAD 00000, MISCMEM 00011, OPIMM 00100, AUIPC 00101, STORE 01000, OP 01100, LUI 01101, BRANCH 11000, JALR 11001, JAL 11011, SYSTEM 11100}.
  - BRANCH with funct3 010/011.
  - LOAD with funct3 011/110/111.
  - STORE with funct3 >= 011.
  - JALR with funct3 != 000.
  - OP with funct7 not 0000000, and not (0100000 with funct3 000/101), and not (0000001 with ENABLE_MULDIV=1).
  - OPIMM funct3 001 with funct7 != 0000000.
  - OPIMM funct3 101 with funct7 not 0000000/0100000.
- Skid (ENABLE_SKID=1): states EMPTY, FULL1 (output reg valid), FULL2 (output + skid valid). O_ready = !skid_valid, registered.
  - FULL1, I_ready=0 and accept: the new instruction goes to skid -> FULL2.
  - FULL2, I_ready=1: skid moves to the output reg -> FULL1. Input is not accepted in FULL2.
  - Accept and output transfer in the same cycle in FULL1: the new instruction replaces the output reg; state stays FULL1.
  - Order is strictly preserved; nothing is dropped or duplicated.
- Output stability: outputs hold while O_valid=1 and I_ready=0.
- Flush: I_flush=1 clears O_valid and skid valid at the next edge and ignores I_valid that cycle. O_ready=1 the following cycle. Flush has priority over simultaneous accept and transfer.
- Data registers of invalid entries are don't-care except after reset, when they are 0.
- Reset mid-operation: returns to EMPTY immediately; in-flight instructions are lost.

Test Plan:
- Reset, then I_instr=0x00500093 (addi x1,x0,5), I_valid=1, I_ready=1 -> next cycle O_valid=1, O_opcode=00100, O_rd=1, O_imm=0x00000005, O_illegal=0; O_rs1=0 combinational in the same cycle.
- 0xFE000EE3 (beq x0,x0,-4) -> O_imm=0xFFFFFFFC, O_branchmask=000001. 0x123452B7 (lui x5) -> O_imm=0x12345000, O_rd=5.
- 0x023100B3 (mul x1,x2,x3): ENABLE_MULDIV=0 -> O_illegal=1; ENABLE_MULDIV=1 -> O_illegal=0, O_funct7=0000001. 0x00000000 -> O_illegal=1.
- Backpressure: stream 4 instructions with I_ready=0 for 3 cycles -> O_ready falls after 2 accepts. Release I_ready -> all 4 delivered in order, none lost or duplicated, outputs stable while stalled.
- Flush in FULL2 with I_valid=1 -> next cycle O_valid=0, O_ready=1; flushed instructions never appear.
- Assert I_reset asynchronously mid-stream (between clock edges) -> O_valid=0 and O_imm=0 immediately, O_ready=1; normal operation resumes after release.
